// File: rtl/pacman_dir_buffer.sv
// Turn buffer between the raw keycode and the Pac-Man motion block: queues turns blocked by a wall.
// Build option DIR_BUF_CONTINUOUS_EN selects arcade mode (keep moving after key release).
module pacman_dir_buffer #(
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       restart,
  input  logic [7:0] keycode_in,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [7:0] keycode_out,
  output logic [1:0] cur_dir,
  output logic       pending_valid,
  output logic [1:0] pending_dir
);

  localparam logic [7:0] HOLD_CNT     = 8'(HOLD_FRAMES);
  localparam logic       HOLD_ENABLED = (HOLD_FRAMES != 0);

  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVING    = 2'd1,
    ST_TURN_PEND = 2'd2
  } state_t;

  // Register state
  logic       cur_valid_q, cur_valid_d;
  logic [1:0] cur_dir_q, cur_dir_d;
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  logic [7:0] pend_cnt_q, pend_cnt_d;
  logic [7:0] keycode_q, keycode_d;

  // Decoded request and wall probes
  logic       req_valid;
  logic [1:0] req_dir;
  logic       req_open;
  logic       pend_open;

  // Derived FSM state, visible for probing and assertions
  state_t     state;

  function automatic logic dir_open(input logic [1:0] d,
                                    input logic [4:0] l, input logic [4:0] r,
                                    input logic [4:0] b, input logic [4:0] t);
    logic [4:0] probe;
    case (d)
      DIR_L:   probe = l;
      DIR_R:   probe = r;
      DIR_D:   probe = b;
      default: probe = t;
    endcase
    return (probe == 5'd0);
  endfunction

  function automatic logic [7:0] encode_dir(input logic [1:0] d);
    case (d)
      DIR_L:   return 8'h04;
      DIR_R:   return 8'h07;
      DIR_D:   return 8'h16;
      default: return 8'h1A;
    endcase
  endfunction

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_L;
    case (keycode_in)
      8'h04:   req_dir = DIR_L;
      8'h07:   req_dir = DIR_R;
      8'h16:   req_dir = DIR_D;
      8'h1A:   req_dir = DIR_U;
      default: req_valid = 1'b0;
    endcase
  end

  assign req_open  = dir_open(req_dir, mapL, mapR, mapB, mapT);
  assign pend_open = dir_open(pend_dir_q, mapL, mapR, mapB, mapT);

  always_comb begin
    if (pend_valid_q)     state = ST_TURN_PEND;
    else if (cur_valid_q) state = ST_MOVING;
    else                  state = ST_IDLE;
  end

  // Next-state logic; the branches are ordered so that the first matching rule wins
  always_comb begin
    cur_valid_d  = cur_valid_q;
    cur_dir_d    = cur_dir_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    pend_cnt_d   = pend_cnt_q;

    if (restart) begin
      cur_valid_d  = 1'b0;
      cur_dir_d    = DIR_L;
      pend_valid_d = 1'b0;
      pend_dir_d   = DIR_L;
      pend_cnt_d   = 8'd0;
    end else if (req_valid && req_open) begin
      // Open corridor: take the turn now, reversals included
      cur_dir_d    = req_dir;
      cur_valid_d  = 1'b1;
      pend_valid_d = 1'b0;
    end else if (req_valid && cur_valid_q && (req_dir == cur_dir_q)) begin
      // Pushing into a wall along the current direction: nothing to queue
      cur_dir_d    = cur_dir_q;
    end else if (req_valid) begin
      // Blocked turn (or blocked start from IDLE): queue it, newest request wins
      if (HOLD_ENABLED) begin
        pend_dir_d   = req_dir;
        pend_valid_d = 1'b1;
        pend_cnt_d   = HOLD_CNT;
      end
    end else begin
`ifdef DIR_BUF_CONTINUOUS_EN
      if (pend_valid_q) begin
        if (pend_open) begin
          cur_dir_d    = pend_dir_q;
          cur_valid_d  = 1'b1;
          pend_valid_d = 1'b0;
        end else if (pend_cnt_q <= 8'd1) begin
          pend_valid_d = 1'b0;
          pend_cnt_d   = 8'd0;
        end else begin
          pend_cnt_d   = pend_cnt_q - 8'd1;
        end
      end
`else
      // Held-key mode: releasing the key stops Pac-Man and forgets any queued turn
      cur_valid_d  = 1'b0;
      pend_valid_d = 1'b0;
`endif
    end

    keycode_d = cur_valid_d ? encode_dir(cur_dir_d) : 8'h00;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cur_valid_q  <= 1'b0;
      cur_dir_q    <= DIR_L;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_L;
      pend_cnt_q   <= 8'd0;
      keycode_q    <= 8'h00;
    end else begin
      cur_valid_q  <= cur_valid_d;
      cur_dir_q    <= cur_dir_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      pend_cnt_q   <= pend_cnt_d;
      keycode_q    <= keycode_d;
    end
  end

  assign keycode_out   = keycode_q;
  assign cur_dir       = cur_dir_q;
  assign pending_valid = pend_valid_q;
  assign pending_dir   = pend_dir_q;

endmodule

// File: tb/tb_pacman_dir_buffer.sv
// Directed bench for pacman_dir_buffer; expectations follow the DIR_BUF_CONTINUOUS_EN setting.
// A second instance with HOLD_FRAMES=0 shares the stimulus to cover disabled turn queuing.
module tb_pacman_dir_buffer;

  logic       frame_clk;
  logic       Reset;
  logic       restart;
  logic [7:0] keycode_in;
  logic [4:0] mapL, mapR, mapB, mapT;

  logic [7:0] keycode_out, keycode_out0;
  logic [1:0] cur_dir, cur_dir0;
  logic       pending_valid, pending_valid0;
  logic [1:0] pending_dir, pending_dir0;

  int checks = 0;
  int errors = 0;

  pacman_dir_buffer #(.HOLD_FRAMES(30)) u_dut (
    .frame_clk(frame_clk), .Reset(Reset), .restart(restart), .keycode_in(keycode_in),
    .mapL(mapL), .mapR(mapR), .mapB(mapB), .mapT(mapT),
    .keycode_out(keycode_out), .cur_dir(cur_dir),
    .pending_valid(pending_valid), .pending_dir(pending_dir)
  );

  pacman_dir_buffer #(.HOLD_FRAMES(0)) u_dut0 (
    .frame_clk(frame_clk), .Reset(Reset), .restart(restart), .keycode_in(keycode_in),
    .mapL(mapL), .mapR(mapR), .mapB(mapB), .mapT(mapT),
    .keycode_out(keycode_out0), .cur_dir(cur_dir0),
    .pending_valid(pending_valid0), .pending_dir(pending_dir0)
  );

  // Clock and reset
  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one frame and settle just after the edge
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] key, input logic [4:0] l, input logic [4:0] r,
                       input logic [4:0] b, input logic [4:0] t);
    keycode_in = key;
    mapL = l; mapR = r; mapB = b; mapT = t;
  endtask

  initial begin
    Reset = 1'b1;
    restart = 1'b0;
    drive(8'h04, 5'd0, 5'd0, 5'd0, 5'd0);

    // T1: reset dominates a valid open request
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_key", keycode_out, 8'h00);
      check("t1_pend", {7'd0, pending_valid}, 8'h00);
      check("t1_dir", {6'd0, cur_dir}, 8'h00);
    end
    Reset = 1'b0;

    // T2: open left
    step();
    check("t2_key", keycode_out, 8'h04);
    check("t2_dir", {6'd0, cur_dir}, 8'h00);

    // Blocked along current direction: hold, no queued turn
    drive(8'h04, 5'd5, 5'd0, 5'd0, 5'd0);
    step();
    check("same_dir_key", keycode_out, 8'h04);
    check("same_dir_pend", {7'd0, pending_valid}, 8'h00);

    // T3: blocked up turn is queued, then taken once open
    drive(8'h1A, 5'd0, 5'd0, 5'd0, 5'd3);
    step();
    check("t3_pend", {7'd0, pending_valid}, 8'h01);
    check("t3_pdir", {6'd0, pending_dir}, 8'h03);
    check("t3_key", keycode_out, 8'h04);
    check("t3_h0_pend", {7'd0, pending_valid0}, 8'h00);
    check("t3_h0_key", keycode_out0, 8'h04);
    step();
    check("t3_hold_pend", {7'd0, pending_valid}, 8'h01);
    mapT = 5'd0;
    step();
    check("t3_open_key", keycode_out, 8'h1A);
    check("t3_open_pend", {7'd0, pending_valid}, 8'h00);
    check("t3_open_dir", {6'd0, cur_dir}, 8'h03);
    check("t3_h0_open_key", keycode_out0, 8'h1A);

    // T4: release with an up turn queued behind a wall
    drive(8'h04, 5'd0, 5'd0, 5'd0, 5'd3);
    step();
    check("t4_move_key", keycode_out, 8'h04);
    keycode_in = 8'h1A;
    step();
    check("t4_queue_pend", {7'd0, pending_valid}, 8'h01);
    keycode_in = 8'h00;
`ifdef DIR_BUF_CONTINUOUS_EN
    for (int i = 1; i < 30; i++) begin
      step();
      check("t4_live_pend", {7'd0, pending_valid}, 8'h01);
      check("t4_live_key", keycode_out, 8'h04);
    end
    step();
    check("t4_expire_pend", {7'd0, pending_valid}, 8'h00);
    check("t4_expire_key", keycode_out, 8'h04);
`else
    step();
    check("t4_release_key", keycode_out, 8'h00);
    check("t4_release_pend", {7'd0, pending_valid}, 8'h00);
`endif

    // T5: immediate reversal, then an unmapped keycode
    drive(8'h04, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("t5_left_key", keycode_out, 8'h04);
    keycode_in = 8'h07;
    step();
    check("t5_rev_key", keycode_out, 8'h07);
    check("t5_rev_dir", {6'd0, cur_dir}, 8'h01);
    keycode_in = 8'h2C;
    step();
`ifdef DIR_BUF_CONTINUOUS_EN
    check("t5_nokey_key", keycode_out, 8'h07);
`else
    check("t5_nokey_key", keycode_out, 8'h00);
`endif

    // Newer blocked request overwrites the queued one; held key beats promotion
    drive(8'h07, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    drive(8'h1A, 5'd0, 5'd0, 5'd0, 5'd3);
    step();
    check("ovr_first_pdir", {6'd0, pending_dir}, 8'h03);
    drive(8'h16, 5'd0, 5'd0, 5'd7, 5'd3);
    step();
    check("ovr_second_pdir", {6'd0, pending_dir}, 8'h02);
    check("ovr_key", keycode_out, 8'h07);
    drive(8'h16, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("ovr_take_key", keycode_out, 8'h16);
    check("ovr_take_pend", {7'd0, pending_valid}, 8'h00);

    // Blocked request from IDLE queues without starting motion
    restart = 1'b1;
    step();
    check("idle_restart_key", keycode_out, 8'h00);
    restart = 1'b0;
    drive(8'h07, 5'd0, 5'd1, 5'd0, 5'd0);
    step();
    check("idle_q_pend", {7'd0, pending_valid}, 8'h01);
    check("idle_q_pdir", {6'd0, pending_dir}, 8'h01);
    check("idle_q_key", keycode_out, 8'h00);
    mapR = 5'd0;
    step();
    check("idle_go_key", keycode_out, 8'h07);

    // T6: restart while a turn is pending, then start down
    drive(8'h1A, 5'd0, 5'd0, 5'd0, 5'd3);
    step();
    check("t6_pend", {7'd0, pending_valid}, 8'h01);
    restart = 1'b1;
    step();
    check("t6_rst_key", keycode_out, 8'h00);
    check("t6_rst_pend", {7'd0, pending_valid}, 8'h00);
    restart = 1'b0;
    drive(8'h16, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("t6_down_key", keycode_out, 8'h16);
    check("t6_down_dir", {6'd0, cur_dir}, 8'h02);

    // Reset acts between clock edges
    #2;
    Reset = 1'b1;
    #1;
    check("async_key", keycode_out, 8'h00);
    check("async_dir", {6'd0, cur_dir}, 8'h00);
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
